// File: rtl/max7219_chain_driver_if.sv
// Frame/brightness handshake between the grid logic and the MAX7219 chain driver.
// master drives frames and brightness; slave accepts them when idle.
interface max7219_chain_driver_if #(
  parameter int N_DEV = 2
);
  logic [N_DEV*64-1:0] frame;
  logic                frame_valid;
  logic                frame_ready;
  logic [3:0]          intensity;

  modport master (
    output frame, frame_valid, intensity,
    input  frame_ready
  );

  modport slave (
    input  frame, frame_valid, intensity,
    output frame_ready
  );
endinterface

// File: rtl/max7219_chain_driver.sv
// Serial driver for a daisy chain of MAX7219s: init, row refresh, brightness.
// Optional macro ROW_DIFF_EN: refresh only rows changed since the last frame.
module max7219_chain_driver #(
  parameter int         N_DEV          = 2,
  parameter int         SCLK_DIV       = 16,
  parameter logic [3:0] INTENSITY_INIT = 4'h8
) (
  input  logic                  clk,
  input  logic                  reset,
  max7219_chain_driver_if.slave bus,
  output logic                  din,
  output logic                  cs,
  output logic                  sclk,
  output logic                  busy
);
  localparam int NB = N_DEV * 16;

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_INTEN, S_ROWS
  } st_e;

  typedef enum logic [1:0] {
    P_NONE, P_GAP, P_BIT, P_TAIL
  } ph_e;

  st_e                 state_q;
  ph_e                 ph_q;
  logic [15:0]         div_q;
  logic [15:0]         gap_q;
  logic [7:0]          bit_q;
  logic [2:0]          idx_q;
  logic [7:0]          rows_q;
  logic [3:0]          last_q;
  logic [3:0]          pend_q;
  logic [NB-1:0]       sh_q;
  logic [N_DEV*64-1:0] frm_q;
  logic                cs_q;
  logic                sclk_q;

  logic [NB-1:0]       vec_d;
  logic [15:0]         word;
  logic [2:0]          low;
  logic [7:0]          mask_d;

  assign din             = sh_q[NB-1];
  assign cs              = cs_q;
  assign sclk            = sclk_q;
  assign busy            = (state_q != S_IDLE);
  assign bus.frame_ready = (state_q == S_IDLE);

  // Device N_DEV-1 sits in the top bits so it is shifted out first.
  always_comb begin
    vec_d = '0;
    word  = 16'h0F00;
    if (state_q == S_INTEN) begin
      word = {8'h0A, 4'h0, pend_q};
    end else begin
      case (idx_q)
        3'd0:    word = 16'h0C01;
        3'd1:    word = 16'h0900;
        3'd2:    word = 16'h0B07;
        3'd3:    word = {8'h0A, 4'h0, last_q};
        default: word = 16'h0F00;
      endcase
    end
    for (int d = 0; d < N_DEV; d++) begin
      if (state_q == S_ROWS)
        vec_d[d*16 +: 16] = {4'h0, {1'b0, idx_q} + 4'd1,
                             frm_q[d*64 + 8*int'(idx_q) +: 8]};
      else
        vec_d[d*16 +: 16] = word;
    end
  end

  always_comb begin
    low = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (rows_q[i]) low = 3'(i);
  end

`ifdef ROW_DIFF_EN
  logic [N_DEV*64-1:0] shd_q;
  logic                first_q;
  logic                take;

  assign take = (state_q == S_IDLE) && bus.frame_valid;

  always_comb begin
    mask_d = '0;
    for (int r = 0; r < 8; r++)
      for (int d = 0; d < N_DEV; d++)
        if (first_q ||
            bus.frame[d*64 + r*8 +: 8] != shd_q[d*64 + r*8 +: 8])
          mask_d[r] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_q   <= '0;
      first_q <= 1'b1;
    end else if (take) begin
      shd_q   <= bus.frame;
      first_q <= 1'b0;
    end
  end
`else
  assign mask_d = 8'hFF;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      ph_q    <= P_NONE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      rows_q  <= '0;
      last_q  <= INTENSITY_INIT;
      pend_q  <= INTENSITY_INIT;
      sh_q    <= '0;
      frm_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      unique case (ph_q)
        P_GAP: begin
          if (gap_q == 16'(2*SCLK_DIV-1)) begin
            gap_q <= '0;
            cs_q  <= 1'b0;
            sh_q  <= vec_d;
            bit_q <= '0;
            div_q <= '0;
            ph_q  <= P_BIT;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        P_BIT: begin
          if (div_q == 16'(SCLK_DIV-1)) begin
            div_q  <= '0;
            sclk_q <= !sclk_q;
            // Falling edge: present the next bit for the whole low phase.
            if (sclk_q) begin
              sh_q <= sh_q << 1;
              if (bit_q == 8'(NB-1)) ph_q  <= P_TAIL;
              else                   bit_q <= bit_q + 8'd1;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        P_TAIL: begin
          cs_q <= 1'b1;
          ph_q <= P_NONE;
          if (state_q == S_INIT) idx_q <= idx_q + 3'd1;
        end
        P_NONE: begin
          unique case (state_q)
            S_INIT: begin
              if (idx_q == 3'd5) begin
                state_q <= S_IDLE;
              end else begin
                if (idx_q == 3'd0) last_q <= bus.intensity;
                ph_q <= P_GAP;
              end
            end
            S_IDLE: begin
              if (bus.frame_valid) begin
                frm_q  <= bus.frame;
                rows_q <= mask_d;
              end
              if (bus.intensity != last_q) begin
                pend_q  <= bus.intensity;
                state_q <= S_INTEN;
                ph_q    <= P_GAP;
              end else if (bus.frame_valid) begin
                state_q <= S_ROWS;
              end
            end
            S_INTEN: begin
              last_q  <= pend_q;
              state_q <= (rows_q != 8'd0) ? S_ROWS : S_IDLE;
            end
            S_ROWS: begin
              if (rows_q != 8'd0) begin
                idx_q       <= low;
                rows_q[low] <= 1'b0;
                ph_q        <= P_GAP;
              end else if (bus.intensity != last_q) begin
                pend_q  <= bus.intensity;
                state_q <= S_INTEN;
                ph_q    <= P_GAP;
              end else begin
                state_q <= S_IDLE;
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_max7219_chain_driver.sv
// Bench for max7219_chain_driver: directed frames/brightness, a word-level
// expectation queue and a per-cycle serial protocol monitor.
module tb_max7219_chain_driver;
  localparam int ND = 2;
  localparam int SD = 2;
  localparam int TO = 5000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic din, cs, sclk, busy;

  max7219_chain_driver_if #(.N_DEV(ND)) bus();

  max7219_chain_driver #(
    .N_DEV(ND), .SCLK_DIV(SD), .INTENSITY_INIT(4'h8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .din(din), .cs(cs), .sclk(sclk), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ncs      = 0;

  logic [31:0]  exp_q[$];
  logic [31:0]  rx_log[$];
  logic         m_first = 1'b1;
  logic [127:0] m_shadow = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] logw(input int i);
    if (i < rx_log.size()) return rx_log[i];
    return 32'hDEADBEEF;
  endfunction

  // Each chain transaction as one 32-bit value: device 1 word, then device 0.
  function automatic void push_init(input logic [3:0] i);
    exp_q.push_back({2{16'h0C01}});
    exp_q.push_back({2{16'h0900}});
    exp_q.push_back({2{16'h0B07}});
    exp_q.push_back({2{8'h0A, 4'h0, i}});
    exp_q.push_back({2{16'h0F00}});
  endfunction

  function automatic void push_rows(input logic [127:0] f);
    logic [7:0] b0, b1;
    logic [3:0] a;
    logic       same;
    for (int r = 0; r < 8; r++) begin
      b0   = f[r*8 +: 8];
      b1   = f[64 + r*8 +: 8];
      a    = 4'(r + 1);
      same = 1'b0;
`ifdef ROW_DIFF_EN
      same = !m_first && b0 == m_shadow[r*8 +: 8] &&
             b1 == m_shadow[64 + r*8 +: 8];
`endif
      if (!same) exp_q.push_back({4'h0, a, b1, 4'h0, a, b0});
    end
    m_first  = 1'b0;
    m_shadow = f;
  endfunction

  logic        in_win = 0, p_sclk = 0, p_din = 0, p_rdy = 0, win_seen = 0;
  int          nbits = 0, run = 0, gap = 1000;
  logic [31:0] sh = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_win = 0; nbits = 0; gap = 1000; p_rdy = 0; win_seen = 0;
    end else begin
      chk("ready_vs_busy", 32'(bus.frame_ready), 32'(!busy));
      if (!cs) begin
        if (!in_win) begin
          in_win = 1; nbits = 0; sh = '0; run = 0; ncs++;
          chk("cs_gap", 32'(gap >= 2*SD), 32'd1);
          chk("first_low", 32'(sclk), 32'd0);
          p_sclk = sclk;
        end
        chk("ready_in_xact", 32'(bus.frame_ready), 32'd0);
        if (sclk == p_sclk) run++;
        else begin
          chk("sclk_phase_len", 32'(run), 32'(SD));
          run = 1;
        end
        if (sclk && p_sclk) chk("din_stable", 32'(din), 32'(p_din));
        if (sclk && !p_sclk) begin
          sh = {sh[30:0], din};
          nbits++;
        end
      end else begin
        chk("sclk_idle_low", 32'(sclk), 32'd0);
        if (in_win) begin
          in_win = 0; win_seen = 1; gap = 0;
          chk("bits_per_xact", 32'(nbits), 32'd32);
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_xact actual=%0h required=none", sh);
          end else begin
            chk("word", sh, exp_q.pop_front());
          end
          rx_log.push_back(sh);
        end
        gap++;
      end
      if (bus.frame_ready && !p_rdy && win_seen) begin
        chk("ready_after_cs", 32'(gap), 32'd2);
        chk("queue_at_idle", 32'(exp_q.size()), 32'd0);
        win_seen = 0;
      end
      p_rdy = bus.frame_ready; p_sclk = sclk; p_din = din;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (bus.frame_ready !== 1'b1 && k < TO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TO) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic send_frame(input logic [127:0] f);
    bus.frame = f;
    bus.frame_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    push_rows(f);
    @(negedge clk);
    chk("ready_drop", 32'(bus.frame_ready), 32'd0);
  endtask

  initial begin
    logic [127:0] fa, fb, fd;
    int base, idx, k;
    bus.frame = '0;
    bus.frame_valid = 1'b0;
    bus.intensity = 4'd3;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_ready", 32'(bus.frame_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    reset = 1'b0;
    push_init(4'd3);
    wait_ready();
    chk("init_xacts", 32'(ncs), 32'd5);
    chk("init_w0", logw(0), 32'h0C010C01);
    chk("init_w3", logw(3), 32'h0A030A03);
    chk("init_w4", logw(4), 32'h0F000F00);

    fa = '0;
    fa[7:0] = 8'hA5;
    fa[71:64] = 8'h3C;
    base = ncs;
    idx = rx_log.size();
    send_frame(fa);
    repeat (300) @(negedge clk);
    bus.intensity = 4'd9;
    exp_q.push_back(32'h0A090A09);
    wait_ready();
    chk("rows_inten_xacts", 32'(ncs - base), 32'd9);
    chk("row0_word", logw(idx), 32'h013C01A5);
    chk("row7_word", logw(idx + 7), 32'h08000800);
    chk("inten_word", logw(idx + 8), 32'h0A090A09);

    fb = 128'h1122334455667788_99AABBCCDDEEFF00;
    base = ncs;
    idx = rx_log.size();
    send_frame(fb);
    send_frame(~fb);
    wait_ready();
    chk("held_frame_xacts", 32'(ncs - base), 32'd16);
    chk("b_row0_word", logw(idx), 32'h01880100);
    chk("c_row0_word", logw(idx + 8), 32'h017701FF);

    fd = {8{16'h0F0F}};
    send_frame(fd);
    k = 0;
    while (!(cs === 1'b0 && sclk === 1'b1) && k < TO) begin
      @(negedge clk);
      k++;
    end
    chk("reset_window_found", 32'(k < TO), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_cs", 32'(cs), 32'd1);
    chk("async_sclk", 32'(sclk), 32'd0);
    chk("async_din", 32'(din), 32'd0);
    exp_q.delete();
    m_first = 1'b1;
    repeat (3) @(negedge clk);
    base = ncs;
    idx = rx_log.size();
    reset = 1'b0;
    push_init(4'd9);
    wait_ready();
    chk("reinit_xacts", 32'(ncs - base), 32'd5);
    chk("reinit_w0", logw(idx), 32'h0C010C01);
    chk("reinit_w3", logw(idx + 3), 32'h0A090A09);

`ifdef ROW_DIFF_EN
    begin : diff_test
      logic [127:0] fe, f2;
      fe = 128'h0123456789ABCDEF_FEDCBA9876543210;
      fe[47:40] = 8'h5A;
      base = ncs;
      send_frame(fe);
      wait_ready();
      chk("diff_first_xacts", 32'(ncs - base), 32'd8);
      f2 = fe;
      f2[111:104] = 8'hFF;
      base = ncs;
      idx = rx_log.size();
      send_frame(f2);
      wait_ready();
      chk("diff_one_xact", 32'(ncs - base), 32'd1);
      chk("diff_word", logw(idx), 32'h06FF065A);
      base = ncs;
      send_frame(f2);
      wait_ready();
      repeat (10) @(negedge clk);
      chk("diff_none", 32'(ncs - base), 32'd0);
    end
`endif

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
